// File: rtl/vrc_irq_array.sv
`default_nettype none
// ============================================================================
// Module   : vrc_irq_array
// Purpose  : Array of independent VRC-style IRQ timers with scanline/cycle modes.
// Revision : 1.0
// ============================================================================
module vrc_irq_array #(
    parameter int CHANNELS  = 2,
    parameter int CNT_W     = 8,
    parameter int PS_PERIOD = 341,
    parameter int PS_STEP   = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [7:0]          cpu_data_in,
    input  logic [1:0]          ch_sel,
    input  logic                wr_latch_lo,
    input  logic                wr_latch_hi,
    input  logic                wr_ctrl,
    input  logic                wr_ack,
    input  logic [1:0]          rd_sel,
    output logic [CNT_W-1:0]    rd_count,
    output logic [CHANNELS-1:0] irq_pending,
    output logic                irq
);

    localparam int              PS_W        = $clog2(PS_PERIOD + 1);
    localparam logic [PS_W-1:0] C_PS_PERIOD = PS_W'(PS_PERIOD);
    localparam logic [PS_W-1:0] C_PS_STEP   = PS_W'(PS_STEP);
    localparam logic [PS_W-1:0] C_PS_RELOAD = PS_W'(PS_PERIOD - PS_STEP);

    // One strobe wins per cycle: ctrl > ack > latch_hi > latch_lo.
    logic w_do_ctrl, w_do_ack, w_do_hi, w_do_lo;
    assign w_do_ctrl = wr_ctrl;
    assign w_do_ack  = wr_ack & ~wr_ctrl;
    assign w_do_hi   = wr_latch_hi & ~wr_ctrl & ~wr_ack;
    assign w_do_lo   = wr_latch_lo & ~w_do_hi & ~wr_ctrl & ~wr_ack;

    wire [3:0][CNT_W-1:0]  w_rd_vec;
    wire [CHANNELS-1:0]    w_pend;

    logic [CHANNELS-1:0]   r_irq_pending;
    logic                  r_irq;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [CNT_W-1:0] r_latch;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_latch_nxt;
        logic [PS_W-1:0]  r_ps;
        logic             r_a;
        logic             r_e;
        logic             r_m;
        logic             r_pend;
        logic             w_sel;
        logic             w_ps_wrap;
        logic             w_tick;

        // Out-of-range ch_sel values never match any channel index.
        assign w_sel     = (ch_sel == 2'(i));
        assign w_ps_wrap = (r_ps <= C_PS_STEP);
        assign w_tick    = r_e & (r_m | w_ps_wrap);

        if (CNT_W == 16) begin : g_latch16
            always_comb begin
                w_latch_nxt = r_latch;
                if (w_sel && w_do_lo) w_latch_nxt[7:0]  = cpu_data_in;
                if (w_sel && w_do_hi) w_latch_nxt[15:8] = cpu_data_in;
            end
        end else begin : g_latch8
            always_comb begin
                w_latch_nxt = r_latch;
                if (w_sel && w_do_lo) w_latch_nxt = CNT_W'(cpu_data_in);
            end
        end

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                r_latch <= '0;
                r_cnt   <= '0;
                r_ps    <= C_PS_PERIOD;
                r_a     <= 1'b0;
                r_e     <= 1'b0;
                r_m     <= 1'b0;
                r_pend  <= 1'b0;
            end else begin
                r_latch <= w_latch_nxt;
                if (w_sel && w_do_ctrl) begin
                    r_a    <= cpu_data_in[0];
                    r_e    <= cpu_data_in[1];
                    r_m    <= cpu_data_in[2];
                    r_pend <= 1'b0;
                    if (cpu_data_in[1]) begin
                        r_cnt <= r_latch;
                        r_ps  <= C_PS_PERIOD;
                    end
                end else begin
                    if (w_sel && w_do_ack) begin
                        r_pend <= 1'b0;
                        r_e    <= r_a;
                    end
                    // Placed after the ack so a coincident overflow keeps pending set.
                    if (r_e) begin
                        r_ps <= w_ps_wrap ? (r_ps + C_PS_RELOAD) : (r_ps - C_PS_STEP);
                        if (w_tick) begin
                            if (&r_cnt) begin
                                r_cnt  <= r_latch;
                                r_pend <= 1'b1;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                    end
                end
            end
        end

        assign w_rd_vec[i] = r_cnt;
        assign w_pend[i]   = r_pend;
    end

    for (genvar j = CHANNELS; j < 4; j++) begin : g_pad
        assign w_rd_vec[j] = '0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_irq_pending <= '0;
            r_irq         <= 1'b0;
        end else begin
            r_irq_pending <= w_pend;
            r_irq         <= |w_pend;
        end
    end

    assign rd_count    = w_rd_vec[rd_sel];
    assign irq_pending = r_irq_pending;
    assign irq         = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_vrc_irq_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_vrc_irq_array
// Purpose  : Directed self-checking bench for vrc_irq_array (2x8 and 4x16 builds).
// Revision : 1.0
// ============================================================================
module tb_vrc_irq_array;

    localparam int K_LO = 0, K_HI = 1, K_CTRL = 2, K_ACK = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  cpu_data_in;
    logic [1:0]  ch_sel;
    logic        wr_latch_lo, wr_latch_hi, wr_ctrl, wr_ack;
    logic [1:0]  rd_sel;
    logic [7:0]  rd_count;
    logic [1:0]  irq_pending;
    logic        irq;
    logic [15:0] rd_count4;
    logic [3:0]  irq_pending4;
    logic        irq4;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int cyc0   = 0;

    always #5 clk = ~clk;

    vrc_irq_array dut (
        .clk(clk), .reset_n(reset_n), .cpu_data_in(cpu_data_in), .ch_sel(ch_sel),
        .wr_latch_lo(wr_latch_lo), .wr_latch_hi(wr_latch_hi), .wr_ctrl(wr_ctrl),
        .wr_ack(wr_ack), .rd_sel(rd_sel), .rd_count(rd_count),
        .irq_pending(irq_pending), .irq(irq)
    );

    vrc_irq_array #(.CHANNELS(4), .CNT_W(16)) dut4 (
        .clk(clk), .reset_n(reset_n), .cpu_data_in(cpu_data_in), .ch_sel(ch_sel),
        .wr_latch_lo(wr_latch_lo), .wr_latch_hi(wr_latch_hi), .wr_ctrl(wr_ctrl),
        .wr_ack(wr_ack), .rd_sel(rd_sel), .rd_count(rd_count4),
        .irq_pending(irq_pending4), .irq(irq4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wr(input int kind, input logic [1:0] ch, input logic [7:0] d);
        ch_sel      = ch;
        cpu_data_in = d;
        wr_latch_lo = (kind == K_LO);
        wr_latch_hi = (kind == K_HI);
        wr_ctrl     = (kind == K_CTRL);
        wr_ack      = (kind == K_ACK);
        step();
        wr_latch_lo = 1'b0;
        wr_latch_hi = 1'b0;
        wr_ctrl     = 1'b0;
        wr_ack      = 1'b0;
    endtask

    // Returns the edge (relative to cyc0) at which irq_pending[1] is first seen high.
    task automatic wait_rise(output int t);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (irq_pending[1] === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        chk("scan_rise_seen", 32'(found), 32'd1);
        t = cyc - cyc0;
    endtask

    int t1, t2, t3, t4;

    initial begin
        reset_n = 1'b0; cpu_data_in = 8'h00; ch_sel = 2'd0; rd_sel = 2'd0;
        wr_latch_lo = 1'b0; wr_latch_hi = 1'b0; wr_ctrl = 1'b0; wr_ack = 1'b0;
        step(); step();
        chk("rst_count", 32'(rd_count), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_pending", 32'(irq_pending), 32'h0);
        chk("rst_irq4", 32'(irq4), 32'h0);
        reset_n = 1'b1;
        step();

        // Cycle mode on ch0: FD, FE, FF, overflow reload, irq one edge later.
        wr(K_LO, 2'd0, 8'hFD);
        wr(K_CTRL, 2'd0, 8'h06);
        chk("cyc_load", 32'(rd_count), 32'hFD);
        step(); chk("cyc_fe", 32'(rd_count), 32'hFE);
        step(); chk("cyc_ff", 32'(rd_count), 32'hFF);
        step(); chk("cyc_reload", 32'(rd_count), 32'hFD);
        chk("cyc_irq_latency", 32'(irq), 32'h0);
        step(); chk("cyc_irq", 32'(irq), 32'h1);
        chk("cyc_pending", 32'(irq_pending), 32'h1);

        // Ack with A=0 freezes the counter.
        wr(K_ACK, 2'd0, 8'h00);
        chk("ack0_count", 32'(rd_count), 32'hFF);
        step(); chk("ack0_irq", 32'(irq), 32'h0);
        chk("ack0_frozen", 32'(rd_count), 32'hFF);
        step(); chk("ack0_frozen2", 32'(rd_count), 32'hFF);

        // Ack with A=1 keeps counting.
        wr(K_CTRL, 2'd0, 8'h07);
        step(); step(); step(); step();
        chk("ack1_irq_set", 32'(irq), 32'h1);
        wr(K_ACK, 2'd0, 8'h00);
        chk("ack1_count", 32'(rd_count), 32'hFF);
        step();
        chk("ack1_irq_clr", 32'(irq), 32'h0);
        chk("ack1_continues", 32'(rd_count), 32'hFD);
        step(); step();
        chk("pre_coll_count", 32'(rd_count), 32'hFF);

        // Ack coincident with overflow: pending survives.
        wr(K_ACK, 2'd0, 8'h00);
        chk("ackcoll_reload", 32'(rd_count), 32'hFD);
        step();
        chk("ackcoll_pending", 32'(irq_pending), 32'h1);

        // Latch write leaves counter; ctrl coincident with overflow clears pending.
        wr(K_LO, 2'd0, 8'hF0);
        chk("latch_no_cnt", 32'(rd_count), 32'hFF);
        wr(K_CTRL, 2'd0, 8'h06);
        chk("ctrlcoll_load", 32'(rd_count), 32'hF0);
        step();
        chk("ctrlcoll_irq", 32'(irq), 32'h0);
        chk("ctrlcoll_count", 32'(rd_count), 32'hF1);
        wr(K_CTRL, 2'd0, 8'h00);
        chk("disable_freeze", 32'(rd_count), 32'hF1);

        // Scanline mode on ch1: rises 115 edges after ctrl, then 114/113/114 apart.
        rd_sel = 2'd1;
        wr(K_LO, 2'd1, 8'hFF);
        wr(K_CTRL, 2'd1, 8'h03);
        cyc0 = cyc;
        chk("scan_load", 32'(rd_count), 32'hFF);
        wait_rise(t1);
        chk("scan_first", 32'(t1), 32'd115);
        chk("scan_only_ch1", 32'(irq_pending), 32'h2);
        wr(K_ACK, 2'd1, 8'h00); step();
        chk("scan_ack_irq", 32'(irq), 32'h0);
        wait_rise(t2);
        chk("scan_gap1", 32'(t2 - t1), 32'd114);
        wr(K_ACK, 2'd1, 8'h00); step();
        wait_rise(t3);
        chk("scan_gap2", 32'(t3 - t2), 32'd113);
        wr(K_ACK, 2'd1, 8'h00); step();
        wait_rise(t4);
        chk("scan_gap3", 32'(t4 - t3), 32'd114);

        // Reset mid-count with a coincident ctrl strobe: reset wins.
        rd_sel = 2'd0;
        wr(K_LO, 2'd0, 8'h80);
        wr(K_CTRL, 2'd0, 8'h06);
        chk("mid_load", 32'(rd_count), 32'h80);
        reset_n = 1'b0; ch_sel = 2'd0; cpu_data_in = 8'h06; wr_ctrl = 1'b1;
        step();
        reset_n = 1'b1; wr_ctrl = 1'b0;
        chk("mid_rst_count", 32'(rd_count), 32'h0);
        chk("mid_rst_irq", 32'(irq), 32'h0);
        chk("mid_rst_pending", 32'(irq_pending), 32'h0);
        step(); step(); step();
        chk("mid_rst_hold", 32'(rd_count), 32'h0);
        chk("mid_rst_irq_hold", 32'(irq), 32'h0);

        // 4x16 build: ch2 cycle mode from FFFE, ch3 scanline, ch3 writes isolated.
        rd_sel = 2'd2;
        wr(K_LO, 2'd3, 8'hFF);
        wr(K_CTRL, 2'd3, 8'h02);
        wr(K_LO, 2'd2, 8'hFE);
        wr(K_HI, 2'd2, 8'hFF);
        wr(K_CTRL, 2'd2, 8'h06);
        chk("w16_load", 32'(rd_count4), 32'hFFFE);
        chk("n2_rdsel_oob", 32'(rd_count), 32'h0);
        wr(K_LO, 2'd3, 8'h55);
        chk("w16_isolated", 32'(rd_count4), 32'hFFFF);
        step();
        chk("w16_reload", 32'(rd_count4), 32'hFFFE);
        chk("w16_latency", 32'(irq_pending4), 32'h0);
        step();
        chk("w16_pending", 32'(irq_pending4), 32'h4);
        chk("w16_irq", 32'(irq4), 32'h1);
        rd_sel = 2'd3;
        #1;
        chk("w16_ch3_count", 32'(rd_count4), 32'h00FF);
        chk("n2_ignored_irq", 32'(irq), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vrc_irq_array.md
VRC_IRQ_ARRAY -- requirements
Module: vrc_irq_array

Interface
REQ-001 SHALL have parameter CHANNELS, default 2, meaning the number of independent IRQ timer channels (1..4).
REQ-002 SHALL have parameter CNT_W, default 8, meaning the counter and latch width (8 or 16).
REQ-003 SHALL have parameter PS_PERIOD, default 341, meaning the prescaler reload period in scanline mode.
REQ-004 SHALL have parameter PS_STEP, default 3, meaning the prescaler decrement per clock.
REQ-005 SHALL have port clk, input, 1 bit: CPU M2 clock; all state changes on its rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port cpu_data_in, input, 8 bits: register write data.
REQ-008 SHALL have port ch_sel, input, 2 bits: target channel for all writes; values >= CHANNELS ignore the write.
REQ-009 SHALL have ports wr_latch_lo and wr_latch_hi, input, 1 bit each: write latch bits [7:0] / [15:8]; wr_latch_hi is ignored when CNT_W=8.
REQ-010 SHALL have port wr_ctrl, input, 1 bit: write the control register.
REQ-011 SHALL have port wr_ack, input, 1 bit: acknowledge the IRQ.
REQ-012 SHALL have port rd_sel, input, 2 bits: channel selected for readback.
REQ-013 SHALL have port rd_count, output, CNT_W bits: live counter of channel rd_sel; zero if rd_sel >= CHANNELS.
REQ-014 SHALL have port irq_pending, output, CHANNELS bits: per-channel IRQ flags.
REQ-015 SHALL have port irq, output, 1 bit: OR of irq_pending.

Function
REQ-016 SHALL keep per-channel state: latch[CNT_W], counter[CNT_W], ctrl bits A (after-ack enable), E (enable), M (1=cycle mode), prescaler (integer 1..PS_PERIOD), and a pending flag.
REQ-017 SHALL apply at most one write strobe per cycle; when several are asserted, precedence is wr_ctrl > wr_ack > wr_latch_hi > wr_latch_lo.
REQ-018 SHALL make a latch write update only the addressed byte, taking effect next cycle, and leave the counter unaffected.
REQ-019 SHALL make a wr_ctrl write set A=d[0], E=d[1], M=d[2] and clear pending; if d[1]=1, it SHALL also load counter<=latch and prescaler<=PS_PERIOD.
REQ-020 SHALL make wr_ack clear pending and set E<=A, with counter and prescaler unchanged.
REQ-021 SHALL freeze counter and prescaler while E=0.
REQ-022 SHALL, in scanline mode (E=1, M=0), on each clk: if prescaler <= PS_STEP then prescaler <= prescaler+PS_PERIOD-PS_STEP and clock the counter; else prescaler <= prescaler-PS_STEP.
REQ-023 SHALL, in cycle mode (E=1, M=1), clock the counter every clk while the prescaler keeps running per REQ-022 without clocking.
REQ-024 SHALL define a counter clock as: if counter is all-ones then counter<=latch and pending<=1; else counter<=counter+1 (no other wrap).
REQ-025 SHALL give a counter clock that coincides with wr_ack on the same channel precedence for pending (pending=1 after the edge), while E<=A still applies.
REQ-026 SHALL give wr_ctrl priority over a coincident counter clock on its channel: the counter/prescaler load and the pending clear win.
REQ-027 SHALL leave non-addressed channels running independently on every cycle.
REQ-028 SHALL register irq_pending and irq, asserting them in the cycle after the overflow edge (one-clock latency); rd_count SHALL be combinational from the registers.

Reset
REQ-029 SHALL, on reset_n=0 at a clk edge, clear all latches, counters, A/E/M and pending, set prescalers to PS_PERIOD, and drive irq=0, irq_pending=0, rd_count=0.
REQ-030 SHALL give a reset asserted mid-count priority over all strobes in that cycle; after release, no channel counts until it is re-enabled via wr_ctrl.

Verification
REQ-031 Cycle mode: latch=0xFD, ctrl=0x06 on ch0 -> counter reads FD, FE, FF; on the 3rd clock after the write, counter=FD and irq rises one cycle later.
REQ-032 Scanline mode: latch=0xFF, ctrl=0x02 -> first pending after clock 114; subsequent overflows at spacings 114, 113, 114 (mean 113.667).
REQ-033 Ack: ctrl=0x07, overflow, then wr_ack -> irq=0 and counting continues (E=1); repeat with ctrl=0x06 -> after ack, counter frozen.
REQ-034 Collision: wr_ack in the same cycle as an overflow -> irq_pending stays 1; wr_ctrl in the same cycle as an overflow -> pending=0 and counter=latch.
REQ-035 CHANNELS=4, CNT_W=16: ch2 latch=0xFFFE in cycle mode, ch3 in scanline mode -> only irq_pending[2] after 2 clocks; ch_sel=3 writes do not disturb ch2.
REQ-036 Reset mid-count (counter=0x80): reset_n low for one clk -> all outputs 0, counters hold 0 with E=0 until the next wr_ctrl.
